// File: rtl/pi1_seg7.sv
// PI1 slave that drives an 8-digit common-anode seven-segment display.
// It time-multiplexes the digits and dims them with a per-digit PWM.
module pi1_seg7 #(
  parameter int unsigned ARCHBITSZ = 32,
  parameter int unsigned CLKFREQ   = 50000000,
  parameter int unsigned REFRESHHZ = 1000,
  parameter int unsigned ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8)
) (
  input  logic                   clk_i,
  input  logic                   rst_n,
  input  logic [1:0]             pi1_op_i,
  input  logic [ADDRBITSZ-1:0]   pi1_addr_i,
  input  logic [ARCHBITSZ-1:0]   pi1_data_i,
  output logic [ARCHBITSZ-1:0]   pi1_data_o,
  input  logic [ARCHBITSZ/8-1:0] pi1_sel_i,
  output logic                   pi1_rdy_o,
  output logic [ARCHBITSZ-1:0]   pi1_mapsz_o,
  output logic [7:0]             an_o,
  output logic [6:0]             seg_o,
  output logic                   dp_o
);

  localparam int unsigned PrescRaw = CLKFREQ / (REFRESHHZ * 128);
  localparam int unsigned Presc    = (PrescRaw == 0) ? 1 : PrescRaw;
  localparam int unsigned PW       = (Presc > 1) ? $clog2(Presc) : 1;
  localparam logic [PW-1:0] PrescLast = PW'(Presc - 1);

  logic [31:0]          digits_q, digits_d;
  logic [19:0]          ctrl_q, ctrl_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [3:0]           pwm_q, pwm_d;
  logic [2:0]           digit_q, digit_d;
  logic [15:0]          frame_q, frame_d;
  logic [ARCHBITSZ-1:0] rdata_q;
  logic [7:0]           an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;

  logic        tick, blank, wr_en, rd_en;
  logic [31:0] rdata, digits_m, ctrl_m;
  logic [3:0]  nib;
  logic [7:0]  dp_mask;
  logic        unused_bits;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] sel);
    logic [31:0] res;
    res = old;
    for (int k = 0; k < 4; k++) begin
      if (sel[k]) res[8*k +: 8] = wd[8*k +: 8];
    end
    return res;
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] v);
    unique case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // op encoding: bit 0 set for WRITE/RDWR, bit 1 set for READ/RDWR
  assign wr_en = pi1_op_i[0];
  assign rd_en = pi1_op_i[1];

  always_comb begin
    rdata = 32'h0;
    unique case (pi1_addr_i[1:0])
      2'd0: rdata = digits_q;
      2'd1: rdata = {12'h0, ctrl_q};
      2'd2: rdata = {frame_q, 8'h0, pwm_q, 1'b0, digit_q};
      default: rdata = 32'h0;
    endcase
  end

  always_comb begin
    digits_m = merge(digits_q, pi1_data_i[31:0], pi1_sel_i[3:0]);
    ctrl_m   = merge({12'h0, ctrl_q}, pi1_data_i[31:0], pi1_sel_i[3:0]);
    digits_d = digits_q;
    ctrl_d   = ctrl_q;
    if (wr_en && pi1_addr_i[1:0] == 2'd0) digits_d = digits_m;
    if (wr_en && pi1_addr_i[1:0] == 2'd1) ctrl_d = ctrl_m[19:0];
  end

  always_comb begin
    tick    = (presc_q == PrescLast);
    presc_d = tick ? '0 : presc_q + PW'(1);
    pwm_d   = pwm_q;
    digit_d = digit_q;
    frame_d = frame_q;
    if (tick) begin
      pwm_d = pwm_q + 4'd1;
      if (pwm_q == 4'hF) begin
        digit_d = digit_q + 3'd1;
        if (digit_q == 3'd7) frame_d = frame_q + 16'd1;
      end
    end
  end

  // Blank the last cycle of each digit slot so two anodes never overlap.
  always_comb begin
    blank   = (presc_d == PrescLast) && (pwm_d == 4'hF);
    dp_mask = ctrl_q[15:8];
    nib     = digits_q[{digit_d, 2'b00} +: 4];
    an_d    = 8'hFF;
    if (!blank && ctrl_q[digit_d] && (pwm_d <= ctrl_q[19:16])) an_d[digit_d] = 1'b0;
    seg_d = hex7(nib);
    dp_d  = ~dp_mask[digit_d];
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= 32'h0;
      ctrl_q   <= 20'h0;
      presc_q  <= '0;
      pwm_q    <= 4'h0;
      digit_q  <= 3'd0;
      frame_q  <= 16'h0;
      rdata_q  <= '0;
      an_q     <= 8'hFF;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
    end else begin
      digits_q <= digits_d;
      ctrl_q   <= ctrl_d;
      presc_q  <= presc_d;
      pwm_q    <= pwm_d;
      digit_q  <= digit_d;
      frame_q  <= frame_d;
      if (rd_en) rdata_q <= ARCHBITSZ'(rdata);
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign pi1_data_o  = rdata_q;
  assign pi1_rdy_o   = 1'b1;
  assign pi1_mapsz_o = ARCHBITSZ'(16);
  assign an_o        = an_q;
  assign seg_o       = seg_q;
  assign dp_o        = dp_q;

  assign unused_bits = ^{pi1_addr_i[ADDRBITSZ-1:2], ctrl_m[31:20]};

endmodule

// File: tb/tb_pi1_seg7.sv
// Directed bench for pi1_seg7: register access, scan timing, dimming, status and reset.
module tb_pi1_seg7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pi1_op = 2'd0;
  logic [29:0] pi1_addr = '0;
  logic [31:0] pi1_data = '0;
  logic [31:0] pi1_data_o;
  logic [3:0]  pi1_sel = '0;
  logic        pi1_rdy;
  logic [31:0] pi1_mapsz;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lit0, litx;

  always #5 clk = ~clk;

  pi1_seg7 #(
    .ARCHBITSZ(32),
    .CLKFREQ  (2560),
    .REFRESHHZ(10)
  ) dut (
    .clk_i      (clk),
    .rst_n      (rst_n),
    .pi1_op_i   (pi1_op),
    .pi1_addr_i (pi1_addr),
    .pi1_data_i (pi1_data),
    .pi1_data_o (pi1_data_o),
    .pi1_sel_i  (pi1_sel),
    .pi1_rdy_o  (pi1_rdy),
    .pi1_mapsz_o(pi1_mapsz),
    .an_o       (an),
    .seg_o      (seg),
    .dp_o       (dp)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
          7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[v];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic bus(input logic [1:0] op, input logic [1:0] a, input logic [31:0] d,
                     input logic [3:0] s);
    pi1_op   = op;
    pi1_addr = {28'h0, a};
    pi1_data = d;
    pi1_sel  = s;
    step();
    pi1_op   = 2'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // Checks one full frame; sample n shows the scan state reached after edge n.
  task automatic scan_frame(input logic [31:0] digs, input logic [7:0] en,
                            input logic [7:0] dpm, input logic [3:0] br);
    int d, p;
    logic [7:0] an_e;
    lit0 = 0;
    litx = 0;
    while (cyc % 256 != 255) step();
    for (int i = 0; i < 256; i++) begin
      step();
      d = (cyc / 32) % 8;
      p = (cyc / 2) % 16;
      an_e = 8'hFF;
      if ((cyc % 32 != 31) && en[d] && (p <= int'(br))) an_e[d] = 1'b0;
      check($sformatf("an n=%0d", cyc), {24'h0, an}, {24'h0, an_e});
      check($sformatf("seg n=%0d", cyc), {25'h0, seg}, {25'h0, exp_seg(digs[4*d +: 4])});
      check($sformatf("dp n=%0d", cyc), {31'h0, dp}, {31'h0, ~dpm[d]});
      if (!an[0]) lit0++;
      if (an[7:1] != 7'h7F) litx++;
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset an", {24'h0, an}, 32'hFF);
    check("reset seg", {25'h0, seg}, 32'h7F);
    check("reset dp", {31'h0, dp}, 32'h1);
    check("reset rdy", {31'h0, pi1_rdy}, 32'h1);
    check("reset data_o", pi1_data_o, 32'h0);
    check("mapsz", pi1_mapsz, 32'd16);
    rst_n = 1'b1;
    cyc   = 0;
    bus(2'd2, 2'd2, 32'h0, 4'h0);
    check("status after reset", pi1_data_o, 32'h0);
    bus(2'd2, 2'd1, 32'h0, 4'h0);
    check("ctrl after reset", pi1_data_o, 32'h0);
    bus(2'd2, 2'd0, 32'h0, 4'h0);
    check("digits after reset", pi1_data_o, 32'h0);

    // Basic display, full brightness
    bus(2'd1, 2'd0, 32'h76543210, 4'hF);
    bus(2'd1, 2'd1, 32'h000F00FF, 4'hF);
    scan_frame(32'h76543210, 8'hFF, 8'h00, 4'hF);
    check("digit0 lit cycles", lit0, 31);

    // Byte-masked write, swap, read hold, field masking
    bus(2'd1, 2'd0, 32'hFFFFFFFF, 4'b0010);
    bus(2'd2, 2'd0, 32'h0, 4'h0);
    check("byte write", pi1_data_o, 32'h7654FF10);
    bus(2'd3, 2'd0, 32'hAAAAAAAA, 4'hF);
    check("rdwr old", pi1_data_o, 32'h7654FF10);
    bus(2'd2, 2'd0, 32'h0, 4'h0);
    check("rdwr new", pi1_data_o, 32'hAAAAAAAA);
    bus(2'd1, 2'd3, 32'h12345678, 4'hF);
    check("write holds data_o", pi1_data_o, 32'hAAAAAAAA);
    bus(2'd2, 2'd3, 32'h0, 4'h0);
    check("reserved reads 0", pi1_data_o, 32'h0);
    bus(2'd1, 2'd1, 32'hFFFFFFFF, 4'hF);
    bus(2'd2, 2'd1, 32'h0, 4'h0);
    check("ctrl upper bits", pi1_data_o, 32'h000FFFFF);

    // Dimming and masks
    bus(2'd1, 2'd1, 32'h00030101, 4'hF);
    scan_frame(32'hAAAAAAAA, 8'h01, 8'h01, 4'h3);
    check("dim lit cycles", lit0, 8);
    check("masked digits dark", litx, 0);

    // Status counters
    do_reset();
    repeat (40) step();
    bus(2'd2, 2'd2, 32'h0, 4'h0);
    check("status n=40", pi1_data_o, 32'h00000041);
    while (cyc < 256) step();
    bus(2'd2, 2'd2, 32'hFFFFFFFF, 4'hF);
    check("status frame 1", pi1_data_o, 32'h00010000);
    while (cyc < 600) step();
    bus(2'd2, 2'd2, 32'h0, 4'h0);
    check("status n=600", pi1_data_o, 32'h000200C2);

    // Asynchronous reset while digit 3 is lit
    bus(2'd1, 2'd0, 32'h76543210, 4'hF);
    bus(2'd1, 2'd1, 32'h000F00FF, 4'hF);
    while (cyc % 256 != 106) step();
    check("digit3 an", {24'h0, an}, 32'hF7);
    check("digit3 seg", {25'h0, seg}, {25'h0, 7'b0110000});
    #2;
    rst_n = 1'b0;
    #1;
    check("async an", {24'h0, an}, 32'hFF);
    check("async seg", {25'h0, seg}, 32'h7F);
    check("async data_o", pi1_data_o, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    bus(2'd2, 2'd2, 32'h0, 4'h0);
    check("status after async", pi1_data_o, 32'h0);
    bus(2'd2, 2'd0, 32'h0, 4'h0);
    check("digits after async", pi1_data_o, 32'h0);
    bus(2'd2, 2'd1, 32'h0, 4'h0);
    check("ctrl after async", pi1_data_o, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
